// File: rtl/cnt_mem_if.sv
// Shared address map and the controller-side bus for cnt_mem.
// The controller drives WE/ADDR/DIN; cnt_mem answers on DOUT.
package params;
  localparam logic [7:0] ADDR_VERSION_NUM_MAJOR = 8'h00;
  localparam logic [7:0] ADDR_VERSION_NUM_MINOR = 8'h01;
  localparam logic [7:0] ADDR_FPGA_STATE        = 8'h02;
  localparam logic [7:0] ADDR_CTL_FLAG          = 8'h04;
endpackage

interface cnt_bus_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  WE;
  logic [ADDR_WIDTH-1:0] ADDR;
  logic [DATA_WIDTH-1:0] DIN;
  logic [DATA_WIDTH-1:0] DOUT;

  modport in_port  (input WE, ADDR, DIN, output DOUT);
  modport out_port (output WE, ADDR, DIN, input DOUT);
endinterface

// File: rtl/cnt_mem.sv
// Dual-port shared memory between the host CPU and the controller, with 2-cycle reads.
// Define CNT_MEM_PROTECT_EN to make the version and FPGA-state words controller-only.
module cnt_mem #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CPU_EN,
  input  logic                  CPU_WE,
  input  logic [ADDR_WIDTH-1:0] CPU_ADDR,
  input  logic [DATA_WIDTH-1:0] CPU_DIN,
  output logic [DATA_WIDTH-1:0] CPU_DOUT,
  cnt_bus_if.in_port            cnt_bus,
  output logic                  COLLISION
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

`ifdef CNT_MEM_PROTECT_EN
  localparam bit ProtectEn = 1'b1;
`else
  localparam bit ProtectEn = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic                  cpu_protected;
  logic                  cpu_wr;
  logic                  ctl_wr;
  logic [ADDR_WIDTH-1:0] ctl_addr;
  logic                  collision_d;
  logic                  cpu_hit_d;
  logic                  ctl_hit_d;

  logic                  cpu_rd_q;
  logic [ADDR_WIDTH-1:0] cpu_addr_q;
  logic                  cpu_hit_q;
  logic [DATA_WIDTH-1:0] cpu_old_q;
  logic [ADDR_WIDTH-1:0] ctl_addr_q;
  logic                  ctl_hit_q;
  logic [DATA_WIDTH-1:0] ctl_old_q;

  always_comb begin
    cpu_protected = 1'b0;
    if (ProtectEn) begin
      cpu_protected = (CPU_ADDR == ADDR_WIDTH'(params::ADDR_VERSION_NUM_MAJOR)) ||
                      (CPU_ADDR == ADDR_WIDTH'(params::ADDR_VERSION_NUM_MINOR)) ||
                      (CPU_ADDR == ADDR_WIDTH'(params::ADDR_FPGA_STATE));
    end
    ctl_addr    = cnt_bus.ADDR;
    cpu_wr      = CPU_EN & CPU_WE & ~cpu_protected;
    ctl_wr      = cnt_bus.WE;
    collision_d = cpu_wr & ctl_wr & (CPU_ADDR == ctl_addr);
    // A read whose word is written on the same edge must return the pre-write value.
    cpu_hit_d   = cpu_wr | (ctl_wr & (ctl_addr == CPU_ADDR));
    ctl_hit_d   = ctl_wr | (cpu_wr & (CPU_ADDR == ctl_addr));
  end

  // CPU write is issued last so it wins a same-address collision.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (ctl_wr) begin
        mem_q[ctl_addr] <= cnt_bus.DIN;
      end
      if (cpu_wr) begin
        mem_q[CPU_ADDR] <= CPU_DIN;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cpu_rd_q     <= 1'b0;
      cpu_addr_q   <= '0;
      cpu_hit_q    <= 1'b0;
      cpu_old_q    <= '0;
      CPU_DOUT     <= '0;
      ctl_addr_q   <= '0;
      ctl_hit_q    <= 1'b0;
      ctl_old_q    <= '0;
      cnt_bus.DOUT <= '0;
      COLLISION    <= 1'b0;
    end else begin
      COLLISION <= collision_d;

      cpu_rd_q <= CPU_EN;
      if (CPU_EN) begin
        cpu_addr_q <= CPU_ADDR;
        cpu_hit_q  <= cpu_hit_d;
        cpu_old_q  <= mem_q[CPU_ADDR];
      end
      if (cpu_rd_q) begin
        CPU_DOUT <= cpu_hit_q ? cpu_old_q : mem_q[cpu_addr_q];
      end

      ctl_addr_q   <= ctl_addr;
      ctl_hit_q    <= ctl_hit_d;
      ctl_old_q    <= mem_q[ctl_addr];
      cnt_bus.DOUT <= ctl_hit_q ? ctl_old_q : mem_q[ctl_addr_q];
    end
  end

endmodule

// File: tb/tb_cnt_mem.sv
// Randomized + directed bench for cnt_mem: a word-array reference model feeds a
// per-cycle expectation queue that a separate monitor drains and compares.
module tb_cnt_mem;
  import params::*;

`ifdef CNT_MEM_PROTECT_EN
  localparam bit ProtectEn = 1'b1;
`else
  localparam bit ProtectEn = 1'b0;
`endif

  logic        CLK;
  logic        RST;
  logic        CPU_EN;
  logic        CPU_WE;
  logic [7:0]  CPU_ADDR;
  logic [15:0] CPU_DIN;
  logic [15:0] CPU_DOUT;
  logic        COLLISION;

  cnt_bus_if #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) bus ();

  cnt_mem #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .CPU_EN    (CPU_EN),
    .CPU_WE    (CPU_WE),
    .CPU_ADDR  (CPU_ADDR),
    .CPU_DIN   (CPU_DIN),
    .CPU_DOUT  (CPU_DOUT),
    .cnt_bus   (bus),
    .COLLISION (COLLISION)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    int          due;
    int          kind;  // 0 COLLISION, 1 CPU_DOUT, 2 cnt_bus.DOUT
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          edge_cnt = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  // Reference model state: the word array plus reads still in flight.
  logic [15:0] ref_mem [256];
  logic [15:0] pend_ctl;
  logic        pend_cpu_v;
  logic [15:0] pend_cpu_val;
  logic [15:0] cpu_prev;

  function automatic logic is_prot(input logic [7:0] a);
    return ProtectEn && (a == ADDR_VERSION_NUM_MAJOR || a == ADDR_VERSION_NUM_MINOR ||
                         a == ADDR_FPGA_STATE);
  endfunction

  function automatic logic [7:0] pick_addr();
    logic [7:0] a;
    if ($urandom_range(0, 9) < 8) a = 8'($urandom_range(0, 7));
    else                          a = 8'($urandom_range(0, 255));
    return a;
  endfunction

  // One clock: drive inputs, predict outputs after the coming edge, then take the edge.
  task automatic cyc(input logic rst, input logic en, input logic we, input logic [7:0] ca,
                     input logic [15:0] cd, input logic bwe, input logic [7:0] ba,
                     input logic [15:0] bd);
    int          e;
    logic        col;
    logic        cw;
    logic [15:0] ctl_after;
    logic [15:0] cpu_after;
    @(negedge CLK);
    RST = rst; CPU_EN = en; CPU_WE = we; CPU_ADDR = ca; CPU_DIN = cd;
    bus.WE = bwe; bus.ADDR = ba; bus.DIN = bd;
    e = edge_cnt + 1;
    col = 1'b0;
    if (rst) begin
      ctl_after  = '0;
      cpu_after  = '0;
      for (int i = 0; i < 256; i++) ref_mem[i] = '0;
      pend_ctl   = '0;
      pend_cpu_v = 1'b0;
    end else begin
      ctl_after = pend_ctl;
      cpu_after = pend_cpu_v ? pend_cpu_val : cpu_prev;
      pend_ctl   = ref_mem[ba];
      pend_cpu_v = en;
      if (en) pend_cpu_val = ref_mem[ca];
      cw  = en && we && !is_prot(ca);
      col = cw && bwe && (ca == ba);
      if (bwe) ref_mem[ba] = bd;
      if (cw)  ref_mem[ca] = cd;
    end
    cpu_prev = cpu_after;
    exp_q.push_back('{due: e, kind: 0, val: {15'd0, col}});
    exp_q.push_back('{due: e, kind: 1, val: cpu_after});
    exp_q.push_back('{due: e, kind: 2, val: ctl_after});
    @(posedge CLK);
  endtask

  task automatic idle(input logic [7:0] ba);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, ba, 16'h0000);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h, expected %h", name, edge_cnt, act, req);
    end
  endtask

  // Monitor: after every edge, compare all outputs predicted for that edge.
  initial begin
    exp_t        x;
    logic [15:0] act;
    forever begin
      @(posedge CLK);
      edge_cnt++;
      #1;
      while (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
        x = exp_q.pop_front();
        if (x.due < edge_cnt) begin
          check("stale_expectation", 16'(x.due), 16'(edge_cnt));
        end else begin
          unique case (x.kind)
            0:       begin act = {15'd0, COLLISION}; check("COLLISION", act, x.val); end
            1:       check("CPU_DOUT", CPU_DOUT, x.val);
            default: check("bus_DOUT", bus.DOUT, x.val);
          endcase
        end
      end
    end
  end

  initial begin
    RST = 1'b1; CPU_EN = 1'b0; CPU_WE = 1'b0; CPU_ADDR = '0; CPU_DIN = '0;
    bus.WE = 1'b0; bus.ADDR = '0; bus.DIN = '0;
    pend_ctl = '0; pend_cpu_v = 1'b0; pend_cpu_val = '0; cpu_prev = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;

    repeat (2) cyc(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 8'h00, 16'h0000);

    // Controller reads a cleared flag word.
    repeat (3) idle(ADDR_CTL_FLAG);
    // Host write, then controller read of the same word one edge later.
    cyc(1'b0, 1'b1, 1'b1, ADDR_CTL_FLAG, 16'h0101, 1'b0, 8'h00, 16'h0000);
    repeat (4) idle(ADDR_CTL_FLAG);
    // Same-address dual write: host value kept, one-cycle collision pulse.
    cyc(1'b0, 1'b1, 1'b1, ADDR_CTL_FLAG, 16'h0002, 1'b1, ADDR_CTL_FLAG, 16'h0100);
    repeat (3) idle(ADDR_CTL_FLAG);
    // Controller write while host reads same word: read-first.
    cyc(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b1, 8'h10, 16'h00A5);
    cyc(1'b0, 1'b1, 1'b0, 8'h10, 16'h0000, 1'b0, 8'h10, 16'h0000);
    repeat (3) idle(8'h10);
    // Protected word: controller writes, host tries to overwrite, host reads back.
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b1, ADDR_FPGA_STATE, 16'h0001);
    cyc(1'b0, 1'b1, 1'b1, ADDR_FPGA_STATE, 16'hFFFF, 1'b0, ADDR_FPGA_STATE, 16'h0000);
    cyc(1'b0, 1'b1, 1'b0, ADDR_FPGA_STATE, 16'h0000, 1'b0, ADDR_FPGA_STATE, 16'h0000);
    repeat (3) idle(ADDR_FPGA_STATE);
    // Reset mid-sequence wipes written data and in-flight reads.
    cyc(1'b0, 1'b1, 1'b1, 8'h20, 16'h1234, 1'b0, 8'h20, 16'h0000);
    cyc(1'b0, 1'b1, 1'b0, 8'h20, 16'h0000, 1'b0, 8'h20, 16'h0000);
    cyc(1'b1, 1'b1, 1'b0, 8'h20, 16'h0000, 1'b0, 8'h20, 16'h0000);
    cyc(1'b0, 1'b1, 1'b0, 8'h20, 16'h0000, 1'b0, 8'h20, 16'h0000);
    repeat (3) idle(8'h20);

    // Randomized traffic concentrated on a few addresses to provoke overlaps.
    for (int n = 0; n < 500; n++) begin
      cyc(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          pick_addr(), 16'($urandom), 1'($urandom_range(0, 1)), pick_addr(), 16'($urandom));
    end
    repeat (4) idle(8'h00);

    repeat (3) @(posedge CLK);
    #2;
    check("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
